cordic_vectoring: RTL

CORDIC_VECTORING -- requirements
Module: cordic_vectoring

---
 rtl/cordic_vectoring.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/cordic_vectoring.sv
// Fully pipelined vectoring-mode CORDIC: atan2(y,x) in Q3.29 and magnitude in Q2.14 from a Q2.14 vector.
// Define CORDIC_VEC_GAIN_COMP_EN to add the 1/K gain stage (latency STAGES+2, otherwise STAGES+1).
module cordic_vectoring #(
  parameter int unsigned STAGES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] y_in,
  output logic signed [31:0] theta_out,
  output logic        [15:0] mag_out,
  output logic               valid_out
);

  localparam int unsigned IW    = 16;
  localparam int unsigned GUARD = 2;
  localparam int unsigned XW    = 20;
  localparam int unsigned ZW    = 32;
  localparam int unsigned PW    = XW + 16;
  localparam logic signed [ZW-1:0] PI_Z = 32'sd1686629713;

  // atan(2^-i) in Q3.29, rounded to nearest
  function automatic logic signed [ZW-1:0] atan_lut(input int idx);
    case (idx)
      0:       atan_lut = 32'sd421657428;
      1:       atan_lut = 32'sd248918915;
      2:       atan_lut = 32'sd131521918;
      3:       atan_lut = 32'sd66762579;
      4:       atan_lut = 32'sd33510843;
      5:       atan_lut = 32'sd16771758;
      6:       atan_lut = 32'sd8387925;
      7:       atan_lut = 32'sd4194219;
      8:       atan_lut = 32'sd2097141;
      9:       atan_lut = 32'sd1048575;
      10:      atan_lut = 32'sd524288;
      11:      atan_lut = 32'sd262144;
      12:      atan_lut = 32'sd131072;
      13:      atan_lut = 32'sd65536;
      14:      atan_lut = 32'sd32768;
      15:      atan_lut = 32'sd16384;
      default: atan_lut = '0;
    endcase
  endfunction

  function automatic logic [15:0] sat_u16(input logic signed [PW-1:0] v);
    if (v[PW-1]) begin
      sat_u16 = '0;
    end else if (v > PW'(65535)) begin
      sat_u16 = 16'hFFFF;
    end else begin
      sat_u16 = v[15:0];
    end
  endfunction

  // Register 0 holds the pre-rotated sample, register i the result of iteration i-1.
  logic signed [XW-1:0] x_q [STAGES];
  logic signed [XW-1:0] y_q [STAGES];
  logic signed [ZW-1:0] z_q [STAGES];
  logic signed [XW-1:0] x_d [STAGES];
  logic signed [XW-1:0] y_d [STAGES];
  logic signed [ZW-1:0] z_d [STAGES];
  logic [STAGES-1:0]    v_q;
  logic [STAGES-1:0]    zero_q;
  logic                 zero_d;
  logic signed [XW-1:0] x_pre;
  logic signed [XW-1:0] y_pre;
  logic signed [XW-1:0] xf_d;
  logic signed [ZW-1:0] zf_d;

  logic                 fin_v;
  logic                 fin_zero;
  logic signed [ZW-1:0] fin_z;
  logic        [15:0]   fin_mag;

  // Two fractional guard bits; two headroom bits cover negation of -1.0 and CORDIC gain.
  always_comb begin
    x_pre  = {{(XW-IW-GUARD){x_in[IW-1]}}, x_in, {GUARD{1'b0}}};
    y_pre  = {{(XW-IW-GUARD){y_in[IW-1]}}, y_in, {GUARD{1'b0}}};
    zero_d = (x_in == '0) && (y_in == '0);
    if (x_in[IW-1]) begin
      x_d[0] = -x_pre;
      y_d[0] = -y_pre;
      z_d[0] = y_in[IW-1] ? -PI_Z : PI_Z;
    end else begin
      x_d[0] = x_pre;
      y_d[0] = y_pre;
      z_d[0] = '0;
    end

    for (int i = 1; i < STAGES; i++) begin
      if (!y_q[i-1][XW-1]) begin
        x_d[i] = x_q[i-1] + (y_q[i-1] >>> (i-1));
        y_d[i] = y_q[i-1] - (x_q[i-1] >>> (i-1));
        z_d[i] = z_q[i-1] + atan_lut(i-1);
      end else begin
        x_d[i] = x_q[i-1] - (y_q[i-1] >>> (i-1));
        y_d[i] = y_q[i-1] + (x_q[i-1] >>> (i-1));
        z_d[i] = z_q[i-1] - atan_lut(i-1);
      end
    end

    // Last iteration only needs x and z; its y residual is never used.
    if (!y_q[STAGES-1][XW-1]) begin
      xf_d = x_q[STAGES-1] + (y_q[STAGES-1] >>> (STAGES-1));
      zf_d = z_q[STAGES-1] + atan_lut(STAGES-1);
    end else begin
      xf_d = x_q[STAGES-1] - (y_q[STAGES-1] >>> (STAGES-1));
      zf_d = z_q[STAGES-1] - atan_lut(STAGES-1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
    end else begin
      v_q <= {v_q[STAGES-2:0], valid_in};
    end
  end

  // Data registers load only alongside a valid sample.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      x_q[0]    <= x_d[0];
      y_q[0]    <= y_d[0];
      z_q[0]    <= z_d[0];
      zero_q[0] <= zero_d;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (v_q[i-1]) begin
        x_q[i]    <= x_d[i];
        y_q[i]    <= y_d[i];
        z_q[i]    <= z_d[i];
        zero_q[i] <= zero_q[i-1];
      end
    end
  end

`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam logic signed [PW-1:0] INV_K = PW'(19898);
  localparam logic signed [PW-1:0] G_RND = PW'(1) <<< (14 + GUARD);

  logic signed [XW-1:0] xf_q;
  logic signed [ZW-1:0] zf_q;
  logic                 zerof_q;
  logic                 vf_q;
  logic signed [PW-1:0] mag_prod;
  logic signed [PW-1:0] mag_scaled;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vf_q <= 1'b0;
    end else begin
      vf_q <= v_q[STAGES-1];
    end
  end

  always_ff @(posedge clk) begin
    if (v_q[STAGES-1]) begin
      xf_q    <= xf_d;
      zf_q    <= zf_d;
      zerof_q <= zero_q[STAGES-1];
    end
  end

  // x * 19898 (Q1.15), rounded, dropping 15 scale bits plus the guard bits
  always_comb begin
    mag_prod   = {{(PW-XW){xf_q[XW-1]}}, xf_q} * INV_K;
    mag_scaled = (mag_prod + G_RND) >>> (15 + GUARD);
  end

  assign fin_v    = vf_q;
  assign fin_z    = zf_q;
  assign fin_zero = zerof_q;
  assign fin_mag  = sat_u16(mag_scaled);
`else
  localparam logic signed [PW-1:0] X_RND = PW'(1) <<< (GUARD - 1);

  logic signed [PW-1:0] mag_scaled;

  always_comb begin
    mag_scaled = ({{(PW-XW){xf_d[XW-1]}}, xf_d} + X_RND) >>> GUARD;
  end

  assign fin_v    = v_q[STAGES-1];
  assign fin_z    = zf_d;
  assign fin_zero = zero_q[STAGES-1];
  assign fin_mag  = sat_u16(mag_scaled);
`endif

  // A zero vector has no defined angle; report 0 instead of the accumulated table sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      theta_out <= '0;
      mag_out   <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= fin_v;
      if (fin_v) begin
        theta_out <= fin_zero ? '0 : fin_z;
        mag_out   <= fin_mag;
      end
    end
  end

endmodule
